// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte handshake in, registered TXD out, LSB first.
// Define UART_TX_FIFO_EN to place a 4-entry FIFO ahead of the framing FSM.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       TXD
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_txd;

    logic        w_bit_done;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_pending;

    assign w_bit_done = (r_cnt == 16'd0);

`ifdef UART_TX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;
    logic       r_full;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_count_next;

    // Full is registered, so a pop in the same cycle does not reopen wr_ready.
    assign wr_ready     = !RESET && !r_full;
    assign w_push       = wr_valid && wr_ready;
    assign w_pending    = (r_count != 3'd0);
    assign w_pop        = w_pending && ((r_state == S_IDLE) ||
                                        (r_state == S_STOP && w_bit_done));
    assign w_count_next = r_count + {2'b00, w_push} - {2'b00, w_pop};
    assign w_load       = w_pop;
    assign w_load_data  = r_mem[r_rptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == 3'd4);
        end
    end

    // NOTE: storage needs no reset; the pointers and count define which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end
`else
    assign wr_ready    = !RESET && (r_state == S_IDLE);
    assign w_pending   = 1'b0;
    assign w_load      = wr_valid && wr_ready;
    assign w_load_data = wr_data;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_START;
                        r_cnt   <= BIT_LAST;
                        r_shift <= w_load_data;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_state <= S_DATA;
                        r_cnt   <= BIT_LAST;
                        r_idx   <= 3'd0;
                        r_txd   <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= BIT_LAST;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        // A queued byte starts its frame straight after the stop bit.
                        if (w_load) begin
                            r_state <= S_START;
                            r_cnt   <= BIT_LAST;
                            r_shift <= w_load_data;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE) || w_pending;
    assign TXD  = r_txd;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 104, meaning CLK cycles per serial bit (12 MHz / 115200, truncated); legal range 2..65535.
REQ-002 SHALL provide port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 SHALL provide port wr_valid  input  1  producer (CPU store path) presents a byte.
REQ-005 SHALL provide port wr_data  input  8  byte to transmit; sampled only when wr_valid && wr_ready.
REQ-006 SHALL provide port wr_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL provide port busy  output  1  frame in progress or byte pending.
REQ-008 SHALL provide port TXD  output  1  serial line, idle high, 8N1, LSB first.

Function
REQ-009 SHALL accept a byte exactly in cycles where wr_valid && wr_ready; wr_data in other cycles ignored.
REQ-010 SHALL implement FSM IDLE -> START -> DATA -> STOP -> (IDLE, or START if a byte is pending); no other states.
REQ-011 SHALL hold each of START, each DATA bit, and STOP for exactly CLKS_PER_BIT cycles via a down-counter reloaded on every bit boundary.
REQ-012 SHALL drive TXD=1 in IDLE, 0 in START, wr_data[i] in DATA bit i (i=0..7), 1 in STOP; TXD registered, glitch-free.
REQ-013 SHALL count DATA bits with a 3-bit index; leave DATA after bit 7 completes, never wrapping into a 9th bit.
REQ-014 SHALL latch the accepted byte into a shift register at frame start; later wr_data changes do not affect the frame in flight.
REQ-015 SHALL, from STOP completion with a byte pending, enter START on the next cycle with no idle bit.
REQ-016 SHALL assert busy whenever state != IDLE or a byte is pending; busy deasserts the cycle IDLE is re-entered with nothing pending.
REQ-017 SHALL produce one frame of exactly 10*CLKS_PER_BIT cycles per accepted byte; no byte dropped or duplicated.

Reset
REQ-018 SHALL, in the cycle after RESET is sampled high, show TXD=1, busy=0, state=IDLE, counters=0, buffered bytes discarded.
REQ-019 SHALL abandon any frame mid-transmission on RESET; TXD returns high immediately, no partial completion after release.
REQ-020 SHALL hold wr_ready=0 while RESET is high and assert it the first cycle after RESET deasserts.

Configuration
REQ-021 SHALL recognise macro UART_TX_FIFO_EN.
REQ-022 SHALL, without UART_TX_FIFO_EN, set wr_ready=1 only in IDLE with RESET low; byte accepted in cycle N drives TXD low from cycle N+1; min accept spacing 10*CLKS_PER_BIT+1 cycles.
REQ-023 SHALL, with UART_TX_FIFO_EN, insert a 4-entry FIFO (2-bit wrapping pointers, 3-bit count) ahead of the FSM; wr_ready = count<4.
REQ-024 SHALL, with FIFO, pop at frame start; byte pushed into empty FIFO in IDLE at cycle N drives TXD low from cycle N+2.
REQ-025 SHALL, with FIFO, on simultaneous push and pop keep count unchanged; push while full impossible since wr_ready=0 (full flag registered, a same-cycle pop does not re-open it).
REQ-026 SHALL, with FIFO, empty on RESET (pointers and count to 0).

Verification (bench overrides CLKS_PER_BIT=4)
REQ-027 SHALL cover: reset then idle 50 cycles -> TXD=1, busy=0, wr_ready=1 throughout.
REQ-028 SHALL cover: write 0x55 -> TXD bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles, 40 cycles total, busy high for those 40.
REQ-029 SHALL cover: write 0xA3 then 0x0F with wr_valid held (FIFO on) -> two frames back-to-back, 80 cycles, no idle gap; FIFO off -> second accepted 41 cycles after first.
REQ-030 SHALL cover: FIFO on, 6 writes held valid -> 5 accepted before wr_ready first drops (4 queued + 1 popped), remaining accepted as slots free; 6 frames in order.
REQ-031 SHALL cover: RESET pulsed during DATA bit 3 of 0xFF -> TXD=1 next cycle, busy=0, no further low bits until a new write.
REQ-032 SHALL cover: wr_data changed mid-frame after accepting 0x81 -> serial output still 0x81.
